// File: rtl/axi4_mm2s_mover.sv
// Memory-mapped to stream read mover: splits one command into 4 KB-safe AXI4 read
// bursts, forwards read beats straight to an AXI-Stream master, then reports a status byte.
module axi4_mm2s_mover #(
  parameter int unsigned C_M_AXI_ADDR_WIDTH      = 32,
  parameter int unsigned C_S_AXIS_CMD_DATA_WIDTH = 73,
  parameter int unsigned C_MAX_BURST_LEN         = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               S_AXIS_CMD_TVALID,
  output logic                               S_AXIS_CMD_TREADY,
  input  logic [C_S_AXIS_CMD_DATA_WIDTH-1:0] S_AXIS_CMD_TDATA,
  output logic                               M_AXIS_STS_TVALID,
  input  logic                               M_AXIS_STS_TREADY,
  output logic [7:0]                         M_AXIS_STS_TDATA,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]      M_AXI_ARADDR,
  output logic [7:0]                         M_AXI_ARLEN,
  output logic [2:0]                         M_AXI_ARSIZE,
  output logic [1:0]                         M_AXI_ARBURST,
  output logic                               M_AXI_ARVALID,
  input  logic                               M_AXI_ARREADY,
  input  logic [31:0]                        M_AXI_RDATA,
  input  logic [1:0]                         M_AXI_RRESP,
  input  logic                               M_AXI_RLAST,
  input  logic                               M_AXI_RVALID,
  output logic                               M_AXI_RREADY,
  output logic [31:0]                        M_AXIS_MM2S_TDATA,
  output logic                               M_AXIS_MM2S_TLAST,
  output logic                               M_AXIS_MM2S_TVALID,
  input  logic                               M_AXIS_MM2S_TREADY
);

  localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned REM_W = 21;
  localparam int unsigned LEN_W = 9;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, STS} state_t;

  state_t           state;
  logic             cmd_ready;
  logic             arvalid;
  logic [AW-1:0]    araddr;
  logic [7:0]       arlen;
  logic             sts_valid;
  logic [7:0]       sts_data;
  logic [AW-1:0]    addr;
  logic [REM_W-1:0] rem;
  logic             eof;
  logic [3:0]       tag;
  logic             slverr;
  logic             decerr;

  // Beats in the next burst: limited by what is left, the burst cap and the 4 KB page end.
  function automatic logic [LEN_W-1:0] burst_len(input logic [11:0] off,
                                                 input logic [REM_W-1:0] r);
    logic [REM_W-1:0] n;
    logic [REM_W-1:0] page;
    page = REM_W'((13'd4096 - {1'b0, off}) >> 2);
    n    = r;
    if (n > REM_W'(C_MAX_BURST_LEN)) n = REM_W'(C_MAX_BURST_LEN);
    if (n > page) n = page;
    return LEN_W'(n);
  endfunction

  logic [31:0]      cmd_addr;
  logic [22:0]      cmd_btt;
  logic             cmd_eof;
  logic [3:0]       cmd_tag;
  logic             cmd_invalid;
  logic             cmd_hs;
  logic [LEN_W-1:0] first_len;
  logic [LEN_W-1:0] next_len;
  logic [LEN_W-1:0] cur_len;
  logic             in_data;
  logic             beat;
  logic             slv_n;
  logic             dec_n;
  logic             unused_cmd;

  assign cmd_addr    = S_AXIS_CMD_TDATA[63:32];
  assign cmd_btt     = S_AXIS_CMD_TDATA[22:0];
  assign cmd_eof     = S_AXIS_CMD_TDATA[30];
  assign cmd_tag     = S_AXIS_CMD_TDATA[67:64];
  assign unused_cmd  = ^{S_AXIS_CMD_TDATA[C_S_AXIS_CMD_DATA_WIDTH-1:68],
                         S_AXIS_CMD_TDATA[31], S_AXIS_CMD_TDATA[29:23]};
  assign cmd_invalid = (cmd_btt == 23'd0) || (cmd_btt[1:0] != 2'b00) || (cmd_addr[1:0] != 2'b00);
  assign cmd_hs      = cmd_ready && S_AXIS_CMD_TVALID;
  assign first_len   = burst_len(cmd_addr[11:0], cmd_btt[22:2]);
  assign next_len    = burst_len(addr[11:0], rem);
  assign cur_len     = LEN_W'(arlen) + LEN_W'(1);

  assign in_data = (state == DATA);
  assign beat    = in_data && M_AXI_RVALID && M_AXIS_MM2S_TREADY;
  assign slv_n   = slverr || (beat && (M_AXI_RRESP == 2'b10));
  assign dec_n   = decerr || (beat && (M_AXI_RRESP == 2'b11));

  // Zero-latency read-data pass-through, gated so nothing leaks outside DATA or in reset.
  assign M_AXIS_MM2S_TDATA  = M_AXI_RDATA;
  assign M_AXIS_MM2S_TVALID = in_data && M_AXI_RVALID;
  assign M_AXI_RREADY       = in_data && M_AXIS_MM2S_TREADY;
  assign M_AXIS_MM2S_TLAST  = in_data && M_AXI_RLAST && (rem == '0) && eof;

  assign S_AXIS_CMD_TREADY = cmd_ready;
  assign M_AXIS_STS_TVALID = sts_valid;
  assign M_AXIS_STS_TDATA  = sts_data;
  assign M_AXI_ARADDR      = araddr;
  assign M_AXI_ARLEN       = arlen;
  assign M_AXI_ARVALID     = arvalid;
  assign M_AXI_ARSIZE      = 3'b010;
  assign M_AXI_ARBURST     = 2'b01;

  // Command / burst / status sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      arlen     <= '0;
      sts_valid <= 1'b0;
      sts_data  <= '0;
      addr      <= '0;
      rem       <= '0;
      eof       <= 1'b0;
      tag       <= '0;
      slverr    <= 1'b0;
      decerr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_hs) begin
            cmd_ready <= 1'b0;
            addr      <= AW'(cmd_addr);
            rem       <= cmd_btt[22:2];
            eof       <= cmd_eof;
            tag       <= cmd_tag;
            slverr    <= 1'b0;
            decerr    <= 1'b0;
            if (cmd_invalid) begin
              sts_valid <= 1'b1;
              sts_data  <= {4'b0001, cmd_tag};
              state     <= STS;
            end else begin
              araddr  <= AW'(cmd_addr);
              arlen   <= 8'(first_len - LEN_W'(1));
              arvalid <= 1'b1;
              state   <= ADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ADDR: begin
          if (M_AXI_ARREADY) begin
            arvalid <= 1'b0;
            addr    <= addr + AW'({cur_len, 2'b00});
            rem     <= rem - REM_W'(cur_len);
            state   <= DATA;
          end
        end
        DATA: begin
          slverr <= slv_n;
          decerr <= dec_n;
          if (beat && M_AXI_RLAST) begin
            if (rem == '0) begin
              sts_valid <= 1'b1;
              sts_data  <= {~(slv_n | dec_n), slv_n, dec_n, 1'b0, tag};
              state     <= STS;
            end else begin
              araddr  <= addr;
              arlen   <= 8'(next_len - LEN_W'(1));
              arvalid <= 1'b1;
              state   <= ADDR;
            end
          end
        end
        STS: begin
          if (M_AXIS_STS_TREADY) begin
            sts_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/axi4_mm2s_mover.md
AXI4_MM2S_MOVER -- requirements
Module: axi4_mm2s_mover

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, AXI read-address width.
REQ-002 SHALL have parameter C_S_AXIS_CMD_DATA_WIDTH, default 73, command word width.
REQ-003 SHALL have parameter C_MAX_BURST_LEN, default 16, maximum beats per read burst (power of 2, 1..256).
REQ-004 SHALL have port: clk  input  1  sole clock, all logic on its rising edge.
REQ-005 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port: S_AXIS_CMD_TVALID  input  1  command valid.
REQ-007 SHALL have port: S_AXIS_CMD_TREADY  output  1  command accept.
REQ-008 SHALL have port: S_AXIS_CMD_TDATA  input  C_S_AXIS_CMD_DATA_WIDTH  command: [22:0] BTT in bytes, [30] EOF, [63:32] address, [67:64] tag; other bits ignored.
REQ-009 SHALL have port: M_AXIS_STS_TVALID  output  1  status valid.
REQ-010 SHALL have port: M_AXIS_STS_TREADY  input  1  status accept.
REQ-011 SHALL have port: M_AXIS_STS_TDATA  output  8  status {OKAY, SLVERR, DECERR, INTERR, tag[3:0]}.
REQ-012 SHALL have port: M_AXI_ARADDR  output  C_M_AXI_ADDR_WIDTH  burst start address.
REQ-013 SHALL have port: M_AXI_ARLEN  output  8  beats minus one.
REQ-014 SHALL have port: M_AXI_ARSIZE  output  3  constant 3'b010.
REQ-015 SHALL have port: M_AXI_ARBURST  output  2  constant 2'b01 (INCR).
REQ-016 SHALL have port: M_AXI_ARVALID  output  1  address valid.
REQ-017 SHALL have port: M_AXI_ARREADY  input  1  address accept.
REQ-018 SHALL have port: M_AXI_RDATA  input  32  read data.
REQ-019 SHALL have port: M_AXI_RRESP  input  2  read response.
REQ-020 SHALL have port: M_AXI_RLAST  input  1  last beat of burst.
REQ-021 SHALL have port: M_AXI_RVALID  input  1  read data valid.
REQ-022 SHALL have port: M_AXI_RREADY  output  1  read data accept.
REQ-023 SHALL have port: M_AXIS_MM2S_TDATA  output  32  stream data (= RDATA).
REQ-024 SHALL have port: M_AXIS_MM2S_TLAST  output  1  end of transfer.
REQ-025 SHALL have port: M_AXIS_MM2S_TVALID  output  1  stream valid.
REQ-026 SHALL have port: M_AXIS_MM2S_TREADY  input  1  stream accept.

Function
REQ-027 SHALL implement states IDLE, ADDR, DATA, STS; one command in flight, one burst outstanding.
REQ-028 IDLE: S_AXIS_CMD_TREADY=1 only in IDLE; on TVALID&&TREADY latch address, BTT, EOF, tag; clear error flags; go ADDR, or STS if command invalid.
REQ-029 Invalid command = BTT==0, BTT[1:0]!=0 or address[1:0]!=0; status then {0,0,0,1,tag}, no AXI traffic issued.
REQ-030 Beats remaining initialised to BTT>>2 (max 2^21-1 beats).
REQ-031 ADDR: ARVALID=1 with ARADDR = current address, ARLEN = len-1, len = min(remaining, C_MAX_BURST_LEN, (4096-address[11:0])>>2); ARADDR/ARLEN stable while ARVALID && !ARREADY; on ARREADY go DATA.
REQ-032 On AR handshake: address += 4*len, remaining -= len.
REQ-033 DATA: TVALID=RVALID, RREADY=TREADY, zero-latency pass-through; no buffering, no beat dropped or duplicated.
REQ-034 TLAST = RLAST && remaining==0 && EOF; TLAST SHALL be 0 on every other beat.
REQ-035 Each beat with RRESP==2 sets SLVERR flag, RRESP==3 sets DECERR flag; transfer continues to completion.
REQ-036 On RLAST handshake: remaining==0 -> STS, else -> ADDR.
REQ-037 STS: TVALID=1, TDATA={~(SLVERR|DECERR), SLVERR, DECERR, 0, tag} (or invalid code per REQ-029), held until TREADY, then IDLE.
REQ-038 Simultaneous TREADY in STS and new CMD_TVALID: command not accepted that cycle; accepted in IDLE next cycle at earliest.
REQ-039 Bursts SHALL never cross a 4 KB boundary; address wrap at 2^C_M_AXI_ADDR_WIDTH not required to be handled.

Reset
REQ-040 rst_n low, at any time incl. mid-burst, SHALL immediately force IDLE and drive all TVALID/ARVALID/RREADY to 0, CMD_TREADY to 0, ARADDR/ARLEN/STS_TDATA to 0.
REQ-041 CMD_TREADY SHALL rise no earlier than the first clk edge after rst_n deasserts.

Verification
REQ-042 Cmd addr=0x1000, BTT=64, EOF=1, tag=5, all ready=1 -> one AR ARLEN=15, 16 beats, TLAST on beat 16 only, status 0x85.
REQ-043 Cmd addr=0x0FF8, BTT=32, EOF=1 -> AR 0x0FF8 ARLEN=1 then AR 0x1000 ARLEN=5; TLAST only on final beat.
REQ-044 Cmd BTT=0 tag=3 -> no ARVALID, status 0x13; BTT=6 -> status 0x1x with INTERR set.
REQ-045 RRESP=2 on beat 3 of 8, EOF=0 -> all 8 beats forwarded, no TLAST, status {0,1,0,0,tag}.
REQ-046 Random TREADY/RVALID/ARREADY/STS_TREADY backpressure plus rst_n pulse mid-DATA -> outputs zeroed during reset, next command completes correctly.
